sub_serial: RTL and testbench
=============================

# sub_serial

Bit-serial two's-complement subtractor for the add_sub datapath, the inverse of the parallel ripple adder. It computes d = a − b − bin one bit per clock, LSB first, through a single full-subtractor cell. It reports the unsigned borrow-out and the signed overflow using a start/busy/done handshake. The ALU sequencer uses it as the subtract unit when area matters more than latency.

## Interface
- WIDTH, default 4, operand and result width (≥ 2)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when the unit can accept (IDLE or DONE)
- a  in  WIDTH  minuend; captured on accepted start
- b  in  WIDTH  subtrahend; captured on accepted start
- bin  in  1  borrow-in; captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; results valid
- d  out  WIDTH  difference
- bout  out  1  borrow out of MSB (unsigned a < b + bin)
- overflow  out  1  signed overflow of a − b − bin

## Operation
- Reset values: state IDLE, busy=0, done=0, d=0, bout=0, overflow=0, bit counter=0, internal borrow=0.
- States: IDLE → RUN on accepted start. RUN → DONE after bit WIDTH−1 is processed. DONE → RUN on start, else DONE → IDLE.
- On accepted start:
  - latch a, b into shift registers; internal borrow ← bin; counter ← 0
  - clear d, bout and overflow to 0
- Each RUN cycle, with ai, bi the current LSBs and br the internal borrow:
  - diff = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - shift diff into d from the MSB end so d is LSB-aligned after WIDTH shifts
  - counter increments
  - on bit WIDTH−1: record br as borrow-into-MSB; bout ← br_next; overflow ← br ^ br_next
- start while busy=1 is ignored; captured operands are not disturbed.
- d, bout and overflow hold their final values from DONE until the next accepted start.
- Reset during RUN aborts immediately. All outputs return to reset values; no done pulse is issued.
- Arithmetic is modulo 2^WIDTH.
  - bout=1 iff unsigned a < b + bin.
  - overflow=1 iff the signed result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].

## Timing
- Start accepted at edge 0.
- busy=1 from edge 0 through edge WIDTH−1 (WIDTH cycles).
- Bit i is computed at edge i+1; state becomes DONE at edge WIDTH.
- done=1 for exactly the cycle after edge WIDTH. Latency start → done is WIDTH cycles; for WIDTH=4, done follows 4 edges after start.
- Back-to-back operation: start held high in the DONE cycle is accepted at the next edge. Throughput is one result per WIDTH+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package add_sub_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE (2 bits)
  - default WIDTH constant, shared with the parallel adder
- Sub-module full_sub_1: combinational 1-bit full subtractor (x, y, bi → diff, bo). It is the mirror of the adder's full-adder cell and is instantiated once.
- Counter width is $clog2(WIDTH).

## Test plan
- a=0011, b=0001, bin=0 → after 4 edges done=1, d=0010, bout=0, overflow=0; busy high for exactly 4 cycles.
- a=0001, b=0011, bin=1 → d=1101, bout=1, overflow=0.
- a=1000, b=0001, bin=0 (−8−1) → d=0111, bout=0, overflow=1.
- a=0111, b=1000, bin=0 (7−(−8)) → d=1111, bout=1, overflow=1.
- Back-to-back and ignored start:
  - pulse start mid-RUN with a=0000, b=0000 → ignored; first result unchanged.
  - assert start during the DONE cycle with a=0000, b=0000, bin=1 → second result d=1111, bout=1, overflow=0, done 4 edges later.
- Assert rst at edge 2 of an operation → busy, done, d, bout and overflow go to 0 immediately (asynchronously). No done pulse follows; the next start behaves normally.

Source files
------------

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared constants and state encoding for the add/sub datapath.
package add_sub_pkg;
    localparam int ADD_SUB_WIDTH = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/full_sub_1.sv
// full_sub_1: combinational 1-bit full subtractor, mirror of the adder's full-adder cell.
module full_sub_1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial two's-complement subtractor d = a - b - bin, LSB first,
// with start/busy/done handshake, unsigned borrow-out and signed overflow.
module sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             diff, bo, accept, last;

    full_sub_1 u_fs (.x(a_q[0]), .y(b_q[0]), .bi(br_q), .diff(diff), .bo(bo));

    assign accept = start && state_q != S_RUN;
    assign last   = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            cnt_d   = '0;
            d_d     = '0;
            bout_d  = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
        end else if (state_q == S_RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = bo;
            d_d   = {diff, d_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            // br_q here is the borrow into the MSB, so its xor with bo flags signed overflow
            if (last) begin
                bout_d  = bo;
                ovf_d   = br_q ^ bo;
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign d        = d_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed checks of the serial subtractor at WIDTH=4.
module tb_sub_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       bin;
    logic       busy, done, bout, overflow;
    logic [3:0] d;
    int         n_asserts = 0;
    int         n_fail = 0;

    sub_serial #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_res(input string tag, input logic [3:0] ed, input logic eb, input logic eo);
        chk({tag, ".done"}, {31'd0, done}, 1);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".d"}, {28'd0, d}, {28'd0, ed});
        chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic run(input string tag, input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       input logic [3:0] ed, input logic eb, input logic eo);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".busy_run"}, {31'd0, busy}, 1);
            chk({tag, ".done_run"}, {31'd0, done}, 0);
            if (i < 3) tick();
        end
        tick();
        chk_res(tag, ed, eb, eo);
        tick();
        chk({tag, ".done_pulse"}, {31'd0, done}, 0);
        chk({tag, ".d_hold"}, {28'd0, d}, {28'd0, ed});
        chk({tag, ".bout_hold"}, {31'd0, bout}, {31'd0, eb});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        chk("rst.busy", {31'd0, busy}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.d", {28'd0, d}, 0);
        chk("rst.bout", {31'd0, bout}, 0);
        chk("rst.ovf", {31'd0, overflow}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run("v1", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
        run("v2", 4'b0001, 4'b0011, 1'b1, 4'b1101, 1'b1, 1'b0);
        run("v3", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
        run("v4", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

        // back-to-back with an ignored mid-run start
        a = 4'b0011; b = 4'b0001; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'b0000; b = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.busy_ign", {31'd0, busy}, 1);
        tick(); tick();
        chk_res("b2b1", 4'b0010, 1'b0, 1'b0);
        a = 4'b0000; b = 4'b0000; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b2.busy", {31'd0, busy}, 1);
        chk("b2b2.done", {31'd0, done}, 0);
        chk("b2b2.d_clr", {28'd0, d}, 0);
        tick(); tick(); tick();
        chk("b2b2.done_early", {31'd0, done}, 0);
        tick();
        chk_res("b2b2", 4'b1111, 1'b1, 1'b0);
        tick();

        // asynchronous reset mid-operation
        a = 4'b0011; b = 4'b0001; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("arst.busy_pre", {31'd0, busy}, 1);
        chk("arst.d_pre", {28'd0, d}, 32'h8);
        rst = 1'b1;
        #1;
        chk("arst.busy", {31'd0, busy}, 0);
        chk("arst.done", {31'd0, done}, 0);
        chk("arst.d", {28'd0, d}, 0);
        chk("arst.bout", {31'd0, bout}, 0);
        chk("arst.ovf", {31'd0, overflow}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arst.no_done", {31'd0, done}, 0);
        end
        run("post", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
